// File: rtl/div8_seq_pkg.sv
// Shared CPU package: divider FSM states, datapath width and DIV opcode.
package div8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div8_state_t;

    localparam int         DIV_W   = 8;
    localparam logic [7:0] OPC_DIV = 8'h04;

endpackage

// File: rtl/div8_seq_step.sv
// div8_step: one restoring-division step. Shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div8_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] q,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] q_nxt
);

    logic [W:0] t;
    logic [W:0] d;

    // Trial subtract; d[W] is the borrow, set when t < divisor.
    always_comb begin
        t       = {rem, q[W-1]};
        d       = t - {1'b0, divisor};
        rem_nxt = d[W] ? t[W-1:0] : d[W-1:0];
        q_nxt   = {q[W-2:0], ~d[W]};
    end

endmodule

// File: rtl/div8_seq.sv
// div8_seq: unsigned restoring divider, one quotient bit per cycle,
// start/done handshake. Optional macro DIV8_DIVZ_EN adds a divz port and a
// one-cycle fast path for divisor 0; without it divisor 0 runs the full
// W steps and still yields quotient all ones, remainder = dividend.
module div8_seq
    import div8_seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
`ifdef DIV8_DIVZ_EN
    ,
    output logic         divz
`endif
);

    localparam int               CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    div8_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     rem_q,   rem_d;
    logic [W-1:0]     q_q,     q_d;
    logic [W-1:0]     dvs_q,   dvs_d;
`ifdef DIV8_DIVZ_EN
    logic             divz_q,  divz_d;
`endif

    logic [W-1:0] step_rem;
    logic [W-1:0] step_q;

    div8_step #(.W(W)) u_step (
        .rem     (rem_q),
        .q       (q_q),
        .divisor (dvs_q),
        .rem_nxt (step_rem),
        .q_nxt   (step_q)
    );

    // Next-state and datapath control. A start seen in the DONE cycle is
    // taken on the edge that leaves DONE, so back-to-back divisions issue
    // every W+1 cycles; start during RUN is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
`ifdef DIV8_DIVZ_EN
        divz_d  = divz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dvs_d   = divisor;
                    q_d     = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV8_DIVZ_EN
                    divz_d  = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = dividend;
                        divz_d  = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = step_rem;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
`ifdef DIV8_DIVZ_EN
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
`ifdef DIV8_DIVZ_EN
            divz_q  <= divz_d;
`endif
        end
    end

    // Outputs come straight from state and working registers.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        quotient  = q_q;
        remainder = rem_q;
`ifdef DIV8_DIVZ_EN
        divz      = divz_q;
`endif
    end

endmodule

// File: tb/tb_div8_seq.sv
// Directed bench for div8_seq: vector table plus hand sequences for
// back-to-back issue, start during RUN, mid-operation reset and result hold.
module tb_div8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done;
    logic [7:0] quotient, remainder;
`ifdef DIV8_DIVZ_EN
    logic       divz;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    div8_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV8_DIVZ_EN
        ,
        .divz      (divz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division with a single-cycle start pulse and track done and
    // busy until busy falls (bounded). Called 1 time unit after an edge.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input string tag);
        int first = -1;
        int dn = 0;
        int bc = 0;
        int elat = 8;
`ifdef DIV8_DIVZ_EN
        if (b == 8'd0) elat = 0;
`endif
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            if (done) begin
                dn++;
                if (first < 0) first = k;
            end
            if (busy) bc++;
            else break;
        end
        check({tag, " latency"}, first, elat);
        check({tag, " done pulses"}, dn, 1);
        check({tag, " busy cycles"}, bc, elat + 1);
        check({tag, " quotient"}, int'(quotient), int'(eq));
        check({tag, " remainder"}, int'(remainder), int'(er));
`ifdef DIV8_DIVZ_EN
        check({tag, " divz"}, int'(divz), (b == 8'd0) ? 1 : 0);
`endif
    endtask

    initial begin
        vec_t tbl[10];
        int   dn;
        int   first;
        logic [7:0] hq, hr;

        tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
        tbl[3] = '{8'd100, 8'd3,   8'd33,  8'd1};
        tbl[4] = '{8'd100, 8'd0,   8'd255, 8'd100};
        tbl[5] = '{8'd50,  8'd6,   8'd8,   8'd2};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0};
        tbl[7] = '{8'd255, 8'd255, 8'd1,   8'd0};
        tbl[8] = '{8'd7,   8'd200, 8'd0,   8'd7};
        tbl[9] = '{8'd128, 8'd16,  8'd8,   8'd0};

        // Reset state
        step();
        step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
`ifdef DIV8_DIVZ_EN
        check("reset divz", int'(divz), 0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));
            step();
        end

        // Back-to-back with start held: 255/1 then 5/9; second accept on the
        // edge that ends the first done cycle (index 9), done again at 17.
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        step();
        dividend = 8'd5;
        divisor  = 8'd9;
        dn = 0;
        first = -1;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) step();
            if (done) begin
                dn++;
                if (k == 8) begin
                    check("b2b first quotient", int'(quotient), 255);
                    check("b2b first remainder", int'(remainder), 0);
                end
                if (k > 8 && first < 0) first = k;
            end
            if (k == 9) check("b2b second accepted", int'({busy, done}), 2);
        end
        start = 1'b0;
        check("b2b done count", dn, 2);
        check("b2b second latency", first, 17);
        check("b2b second quotient", int'(quotient), 0);
        check("b2b second remainder", int'(remainder), 5);
        step();
        step();

        // start toggled during RUN of 100/3; operands wiggle too.
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        step();
        dn = 0;
        first = -1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            start    = (k < 7) ? ~start : 1'b0;
            dividend = 8'(k * 37);
            divisor  = 8'(k);
            if (done) begin
                dn++;
                if (first < 0) first = k;
                if (k == 8) begin
                    check("toggle quotient", int'(quotient), 33);
                    check("toggle remainder", int'(remainder), 1);
                end
            end
        end
        start = 1'b0;
        check("toggle latency", first, 8);
        check("toggle done count", dn, 1);
        step();

        // Reset during step 4 of 200/7, then a clean 50/6.
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst quotient", int'(quotient), 0);
        check("midrst remainder", int'(remainder), 0);
        rst = 1'b0;
        step();
        do_div(8'd50, 8'd6, 8'd8, 8'd2, "after rst");

        // Result hold: 20 idle cycles with operands changing.
        hq = quotient;
        hr = remainder;
        for (int k = 0; k < 20; k++) begin
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            step();
            check("hold quotient", int'(quotient), 8);
            check("hold remainder", int'(remainder), 2);
        end
        check("hold stable pair", int'({quotient, remainder}), int'({hq, hr}));

`ifdef DIV8_DIVZ_EN
        // divz clears on the next accept.
        do_div(8'd100, 8'd0, 8'd255, 8'd100, "divz set");
        step();
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("divz cleared on accept", int'(divz), 0);
        for (int k = 0; k < 12; k++) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
